// File: rtl/sourcebuffer_arb.sv
// ============================================================================
// sourcebuffer_arb
// ----------------------------------------------------------------------------
// Arbitrates NREQ requesters onto the two ports (A and B) of a dual-ported
// row buffer. Each cycle up to two requests are granted. The scan starts at a
// rotating pointer and wraps modulo NREQ. The first grant goes to port A and
// the second grant goes to port B. Two writes to the same address are never
// granted together. Port controls are registered one cycle after the grant.
// Read returns are tagged back to their owner through a per-port shift pipe.
//
// Ports:
//   clock, reset        single clock, synchronous active-high reset
//   req/we/addr/wdata   per-requester request, direction, address, write row
//   gnt                 combinational acceptance this cycle
//   rvalid_a/_b         one-hot owner of rdata_a/_b this cycle
//   rdata_a/_b          buffer read data passed straight through from q_a/_b
//   data_*, write_address_*, read_address_*, wren_*   buffer port controls
//   q_a/q_b             buffer read data
//   perf_conflicts      (only with SBUF_ARB_PERF_EN) saturating count of
//                       cycles in which some request was left waiting
//
// Optional feature macro: SBUF_ARB_PERF_EN
// ============================================================================
module sourcebuffer_arb #(
    parameter int WL       = 32,
    parameter int NUM      = 128,
    parameter int AW       = 10,
    parameter int NREQ     = 4,
    parameter int READ_LAT = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        we,
    input  logic [NREQ*AW-1:0]     addr,
    input  logic [NREQ*WL*NUM-1:0] wdata,
    output logic [NREQ-1:0]        gnt,
    output logic [NREQ-1:0]        rvalid_a,
    output logic [NREQ-1:0]        rvalid_b,
    output logic [WL*NUM-1:0]      rdata_a,
    output logic [WL*NUM-1:0]      rdata_b,
    output logic [WL*NUM-1:0]      data_a,
    output logic [WL*NUM-1:0]      data_b,
    output logic [AW-1:0]          write_address_a,
    output logic [AW-1:0]          write_address_b,
    output logic [AW-1:0]          read_address_a,
    output logic [AW-1:0]          read_address_b,
    output logic                   wren_a,
    output logic                   wren_b,
    input  logic [WL*NUM-1:0]      q_a,
    input  logic [WL*NUM-1:0]      q_b
`ifdef SBUF_ARB_PERF_EN
    ,
    output logic [15:0]            perf_conflicts
`endif
);

    localparam int RW = WL * NUM;
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Unpack the flat request buses so that the requesters can be indexed directly.
    logic [AW-1:0] addr_arr  [NREQ];
    logic [RW-1:0] wdata_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign addr_arr[i]  = addr[i*AW +: AW];
        assign wdata_arr[i] = wdata[i*RW +: RW];
    end

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] scan_idx [NREQ];
    logic          sel_vld  [2];
    logic [PW-1:0] sel_idx  [2];
    logic [PW-1:0] last_idx;
    logic [NREQ-1:0] gnt_c;

    // Port state: index 0 is port A and index 1 is port B.
    logic          wren_q  [2], wren_d  [2];
    logic [AW-1:0] waddr_q [2], waddr_d [2];
    logic [AW-1:0] raddr_q [2], raddr_d [2];
    logic [RW-1:0] data_q  [2], data_d  [2];
    logic [READ_LAT:0] pv_q [2], pv_d [2];
    logic [PW-1:0]     po_q [2][READ_LAT+1];
    logic [PW-1:0]     po_d [2][READ_LAT+1];

    // Build the scan order. Position k is the requester that sits k steps
    // after the rotating pointer, wrapping around modulo NREQ.
    always_comb begin
        for (int k = 0; k < NREQ; k++) begin
            scan_idx[k] = PW'((int'(ptr_q) + k) % NREQ);
        end
    end

    // Walk the scan order and pick at most two requests. The first hit
    // always takes port A. A later hit takes port B unless both hits are
    // writes to the same row. In that case the later write is skipped and
    // the walk carries on, so the next request in order can still use B.
    always_comb begin
        gnt_c = '0;
        for (int p = 0; p < 2; p++) begin
            sel_vld[p] = 1'b0;
            sel_idx[p] = '0;
        end
        for (int k = 0; k < NREQ; k++) begin
            if (req[scan_idx[k]]) begin
                if (!sel_vld[0]) begin
                    sel_vld[0] = 1'b1;
                    sel_idx[0] = scan_idx[k];
                end else if (!sel_vld[1] &&
                             !(we[sel_idx[0]] && we[scan_idx[k]] &&
                               (addr_arr[sel_idx[0]] == addr_arr[scan_idx[k]]))) begin
                    sel_vld[1] = 1'b1;
                    sel_idx[1] = scan_idx[k];
                end
            end
        end
        for (int p = 0; p < 2; p++) begin
            if (sel_vld[p]) begin
                gnt_c[sel_idx[p]] = 1'b1;
            end
        end
    end

    assign gnt      = reset ? '0 : gnt_c;
    assign last_idx = sel_vld[1] ? sel_idx[1] : sel_idx[0];

    // The pointer moves to just past the last requester that was granted.
    // The next scan therefore starts with the requesters that were passed over.
    always_comb begin
        ptr_d = ptr_q;
        if (sel_vld[0]) begin
            ptr_d = (last_idx == PW'(NREQ - 1)) ? '0 : last_idx + PW'(1);
        end
    end

    // Compute the next port state. A granted write loads the write address,
    // the data and wren. A granted read loads only the read address and
    // injects (valid, owner) into the return pipe. Address and data registers
    // keep their values when the port is idle.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            wren_d[p]  = 1'b0;
            waddr_d[p] = waddr_q[p];
            raddr_d[p] = raddr_q[p];
            data_d[p]  = data_q[p];
            pv_d[p]    = '0;
            for (int s = 0; s <= READ_LAT; s++) begin
                po_d[p][s] = '0;
            end
            for (int s = READ_LAT; s > 0; s--) begin
                pv_d[p][s] = pv_q[p][s-1];
                po_d[p][s] = po_q[p][s-1];
            end
            po_d[p][0] = sel_idx[p];
            if (sel_vld[p]) begin
                if (we[sel_idx[p]]) begin
                    wren_d[p]  = 1'b1;
                    waddr_d[p] = addr_arr[sel_idx[p]];
                    data_d[p]  = wdata_arr[sel_idx[p]];
                end else begin
                    raddr_d[p] = addr_arr[sel_idx[p]];
                    pv_d[p][0] = 1'b1;
                end
            end
        end
    end

    // Register all arbiter state. Reset also empties the read pipes, so reads
    // that were still in flight never raise rvalid after reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q <= '0;
            for (int p = 0; p < 2; p++) begin
                wren_q[p]  <= 1'b0;
                waddr_q[p] <= '0;
                raddr_q[p] <= '0;
                data_q[p]  <= '0;
                pv_q[p]    <= '0;
                for (int s = 0; s <= READ_LAT; s++) begin
                    po_q[p][s] <= '0;
                end
            end
        end else begin
            ptr_q <= ptr_d;
            for (int p = 0; p < 2; p++) begin
                wren_q[p]  <= wren_d[p];
                waddr_q[p] <= waddr_d[p];
                raddr_q[p] <= raddr_d[p];
                data_q[p]  <= data_d[p];
                pv_q[p]    <= pv_d[p];
                for (int s = 0; s <= READ_LAT; s++) begin
                    po_q[p][s] <= po_d[p][s];
                end
            end
        end
    end

    assign wren_a          = wren_q[0];
    assign wren_b          = wren_q[1];
    assign write_address_a = waddr_q[0];
    assign write_address_b = waddr_q[1];
    assign read_address_a  = raddr_q[0];
    assign read_address_b  = raddr_q[1];
    assign data_a          = data_q[0];
    assign data_b          = data_q[1];
    assign rdata_a         = q_a;
    assign rdata_b         = q_b;
    assign rvalid_a        = pv_q[0][READ_LAT] ? (NREQ'(1) << po_q[0][READ_LAT]) : '0;
    assign rvalid_b        = pv_q[1][READ_LAT] ? (NREQ'(1) << po_q[1][READ_LAT]) : '0;

`ifdef SBUF_ARB_PERF_EN
    logic [15:0] perf_q, perf_d;

    // Count the cycles in which at least one asserted request was left
    // ungranted. The counter saturates instead of wrapping.
    always_comb begin
        perf_d = perf_q;
        if (|(req & ~gnt_c) && (perf_q != 16'hFFFF)) begin
            perf_d = perf_q + 16'd1;
        end
    end

    // Register the conflict counter. Reset clears it.
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_conflicts = perf_q;
`endif

endmodule

// File: tb/tb_sourcebuffer_arb.sv
// ============================================================================
// tb_sourcebuffer_arb
// ----------------------------------------------------------------------------
// Directed bench for sourcebuffer_arb using a small row width (8x4 bits).
// applyStimulus drives one cycle of requests. It pushes the hand-derived
// grant, the buffer write and the read return into scoreboards. A monitor
// running on the falling edge pops and compares each entry when the DUT
// presents the matching output. A behavioural two-cycle buffer answers the
// read addresses.
// ============================================================================
module tb_sourcebuffer_arb;

    localparam int WL       = 8;
    localparam int NUM      = 4;
    localparam int AW       = 10;
    localparam int NREQ     = 4;
    localparam int READ_LAT = 2;
    localparam int RW       = WL * NUM;

    logic                 clock = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      req, we;
    logic [NREQ*AW-1:0]   addr;
    logic [NREQ*RW-1:0]   wdata;
    logic [NREQ-1:0]      gnt, rvalid_a, rvalid_b;
    logic [RW-1:0]        rdata_a, rdata_b, data_a, data_b;
    logic [AW-1:0]        write_address_a, write_address_b;
    logic [AW-1:0]        read_address_a, read_address_b;
    logic                 wren_a, wren_b;
    logic [RW-1:0]        q_a, q_b, qa_s0, qb_s0;
`ifdef SBUF_ARB_PERF_EN
    logic [15:0]          perf_conflicts;
`endif

    typedef struct {
        int              cyc;
        logic [NREQ-1:0] own;
        logic [AW-1:0]   a;
        logic [RW-1:0]   d;
    } ev_t;

    ev_t gntQ[$], wrQa[$], wrQb[$], rvQa[$], rvQb[$];

    int cyc        = 0;
    int compared   = 0;
    int mismatched = 0;

    logic [AW-1:0] reqAddr [NREQ];
    logic [RW-1:0] reqData [NREQ];
    logic [RW-1:0] mem     [int];
    logic [RW-1:0] golden  [int];
    ev_t           mon;

    // Free-running clock. The cycle counter advances on every rising edge.
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    sourcebuffer_arb #(
        .WL(WL), .NUM(NUM), .AW(AW), .NREQ(NREQ), .READ_LAT(READ_LAT)
    ) dut (
        .clock(clock), .reset(reset), .req(req), .we(we), .addr(addr),
        .wdata(wdata), .gnt(gnt), .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
        .rdata_a(rdata_a), .rdata_b(rdata_b), .data_a(data_a), .data_b(data_b),
        .write_address_a(write_address_a), .write_address_b(write_address_b),
        .read_address_a(read_address_a), .read_address_b(read_address_b),
        .wren_a(wren_a), .wren_b(wren_b), .q_a(q_a), .q_b(q_b)
`ifdef SBUF_ARB_PERF_EN
        , .perf_conflicts(perf_conflicts)
`endif
    );

    function automatic logic [RW-1:0] initRow(input int a);
        return RW'(32'hA500_0000 + a);
    endfunction

    // Behavioural buffer. The read is sampled before the write in the same
    // edge, so a colliding read sees the old row. Data appears two cycles
    // after the registered read address.
    always @(posedge clock) begin
        qa_s0 <= mem.exists(int'(read_address_a)) ? mem[int'(read_address_a)] : initRow(int'(read_address_a));
        qb_s0 <= mem.exists(int'(read_address_b)) ? mem[int'(read_address_b)] : initRow(int'(read_address_b));
        q_a   <= qa_s0;
        q_b   <= qb_s0;
        if (wren_a) mem[int'(write_address_a)] = data_a;
        if (wren_b) mem[int'(write_address_b)] = data_b;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [RW-1:0] goldenAt(input logic [AW-1:0] a);
        return golden.exists(int'(a)) ? golden[int'(a)] : initRow(int'(a));
    endfunction

    // Drive one cycle of requests and record the expected effects. ia and ib
    // give the requester expected on port A and on port B (-1 means none).
    // Reads record the row as it was before any write granted in this cycle.
    task automatic applyStimulus(input logic [NREQ-1:0] r, input logic [NREQ-1:0] w,
                                 input int ia, input int ib, input logic [NREQ-1:0] expGnt);
        int  own [2];
        ev_t e;
        req = r;
        we  = w;
        for (int i = 0; i < NREQ; i++) begin
            addr[i*AW +: AW]  = reqAddr[i];
            wdata[i*RW +: RW] = reqData[i];
        end
        e.cyc = cyc; e.own = expGnt; e.a = '0; e.d = '0;
        gntQ.push_back(e);
        own[0] = ia;
        own[1] = ib;
        for (int p = 0; p < 2; p++) begin
            if (own[p] >= 0 && !w[own[p]]) begin
                e.cyc = cyc + 1 + READ_LAT;
                e.own = NREQ'(1) << own[p];
                e.a   = reqAddr[own[p]];
                e.d   = goldenAt(reqAddr[own[p]]);
                if (p == 0) rvQa.push_back(e); else rvQb.push_back(e);
            end
        end
        for (int p = 0; p < 2; p++) begin
            if (own[p] >= 0 && w[own[p]]) begin
                e.cyc = cyc + 1;
                e.own = NREQ'(1) << own[p];
                e.a   = reqAddr[own[p]];
                e.d   = reqData[own[p]];
                if (p == 0) wrQa.push_back(e); else wrQb.push_back(e);
                golden[int'(e.a)] = e.d;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic applyReset(input int n);
        reset = 1'b1;
        req   = '0;
        we    = '0;
        repeat (n) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // Monitor. It pops each scoreboard when the DUT shows the matching output
    // and checks it. Outputs that arrive with no matching entry, and entries
    // whose cycle has passed, are reported as failures.
    always @(negedge clock) begin
        if (gntQ.size() > 0 && gntQ[0].cyc <= cyc) begin
            mon = gntQ.pop_front();
            if (mon.cyc != cyc) checkOutput("gnt_overdue", cyc, mon.cyc);
            else                checkOutput("gnt", gnt, mon.own);
        end
        while (wrQa.size() > 0 && wrQa[0].cyc < cyc) begin
            mon = wrQa.pop_front(); checkOutput("wr_a_missing", cyc, mon.cyc);
        end
        while (wrQb.size() > 0 && wrQb[0].cyc < cyc) begin
            mon = wrQb.pop_front(); checkOutput("wr_b_missing", cyc, mon.cyc);
        end
        while (rvQa.size() > 0 && rvQa[0].cyc < cyc) begin
            mon = rvQa.pop_front(); checkOutput("rvalid_a_missing", cyc, mon.cyc);
        end
        while (rvQb.size() > 0 && rvQb[0].cyc < cyc) begin
            mon = rvQb.pop_front(); checkOutput("rvalid_b_missing", cyc, mon.cyc);
        end
        if (wren_a) begin
            if (wrQa.size() == 0 || wrQa[0].cyc != cyc) checkOutput("wren_a_unexpected", wren_a, 0);
            else begin
                mon = wrQa.pop_front();
                checkOutput("write_address_a", write_address_a, mon.a);
                checkOutput("data_a", data_a, mon.d);
            end
        end
        if (wren_b) begin
            if (wrQb.size() == 0 || wrQb[0].cyc != cyc) checkOutput("wren_b_unexpected", wren_b, 0);
            else begin
                mon = wrQb.pop_front();
                checkOutput("write_address_b", write_address_b, mon.a);
                checkOutput("data_b", data_b, mon.d);
            end
        end
        if (rvalid_a != '0) begin
            if (rvQa.size() == 0 || rvQa[0].cyc != cyc) checkOutput("rvalid_a_unexpected", rvalid_a, 0);
            else begin
                mon = rvQa.pop_front();
                checkOutput("rvalid_a", rvalid_a, mon.own);
                checkOutput("rdata_a", rdata_a, mon.d);
            end
        end
        if (rvalid_b != '0) begin
            if (rvQb.size() == 0 || rvQb[0].cyc != cyc) checkOutput("rvalid_b_unexpected", rvalid_b, 0);
            else begin
                mon = rvQb.pop_front();
                checkOutput("rvalid_b", rvalid_b, mon.own);
                checkOutput("rdata_b", rdata_b, mon.d);
            end
        end
    end

    // Watchdog: stop the run if the main sequence never finishes.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        req   = '0;
        we    = '0;
        addr  = '0;
        wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            reqAddr[i] = '0;
            reqData[i] = '0;
        end

        // Outputs while reset is held.
        repeat (2) @(posedge clock);
        @(negedge clock);
        checkOutput("reset_gnt", gnt, 0);
        checkOutput("reset_wren_a", wren_a, 0);
        checkOutput("reset_wren_b", wren_b, 0);
        checkOutput("reset_rvalid_a", rvalid_a, 0);
        checkOutput("reset_rvalid_b", rvalid_b, 0);
        checkOutput("reset_write_address_a", write_address_a, 0);
        checkOutput("reset_read_address_b", read_address_b, 0);
        checkOutput("reset_data_b", data_b, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Two writes in the first cycle after reset. ptr moves to 2.
        reqAddr[0] = 10'd1; reqData[0] = 32'h1111_0001;
        reqAddr[1] = 10'd2; reqData[1] = 32'h2222_0002;
        applyStimulus(4'b0011, 4'b0011, 0, 1, 4'b0011);
        // Read the same rows back from requesters 2 and 3. ptr moves to 0.
        reqAddr[2] = 10'd1; reqAddr[3] = 10'd2;
        applyStimulus(4'b1100, 4'b0000, 2, 3, 4'b1100);
        applyStimulus(4'b0000, 4'b0000, -1, -1, 4'b0000);
        // Read and write of row 7 in one cycle. The read returns the old row.
        reqAddr[0] = 10'd7; reqData[0] = 32'h7777_0007;
        reqAddr[1] = 10'd7;
        applyStimulus(4'b0011, 4'b0001, 0, 1, 4'b0011);
        // ptr=2: writes 2 and 3 collide on row 9, so 3 is held off. The read
        // from 0 wraps onto port B. ptr moves to 1.
        reqAddr[2] = 10'd9; reqData[2] = 32'h9999_0002;
        reqAddr[3] = 10'd9; reqData[3] = 32'h9999_0003;
        reqAddr[0] = 10'd4;
        applyStimulus(4'b1101, 4'b1100, 2, 0, 4'b0101);
        // Held-off requester 3 is granted next. ptr moves to 0.
        applyStimulus(4'b1000, 4'b1000, 3, -1, 4'b1000);
        // Row 9 now holds requester 3's data.
        reqAddr[1] = 10'd9;
        applyStimulus(4'b0010, 4'b0000, 1, -1, 4'b0010);
        repeat (4) applyStimulus(4'b0000, 4'b0000, -1, -1, 4'b0000);

        // All four requesters write row 5 from ptr=0: one grant per cycle.
        applyReset(2);
        for (int i = 0; i < NREQ; i++) begin
            reqAddr[i] = 10'd5;
            reqData[i] = 32'h5555_0000 + i;
        end
        for (int k = 0; k < 5; k++) begin
`ifdef SBUF_ARB_PERF_EN
            if (k == 4) checkOutput("perf_conflicts", perf_conflicts, 4);
`endif
            applyStimulus(4'b1111, 4'b1111, k % NREQ, -1, 4'(1 << (k % NREQ)));
        end
        repeat (3) applyStimulus(4'b0000, 4'b0000, -1, -1, 4'b0000);

        // Four continuous readers: grants alternate 0011 / 1100.
        applyReset(1);
        reqAddr[0] = 10'd5; reqAddr[1] = 10'd1; reqAddr[2] = 10'd2; reqAddr[3] = 10'd9;
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) applyStimulus(4'b1111, 4'b0000, 0, 1, 4'b0011);
            else            applyStimulus(4'b1111, 4'b0000, 2, 3, 4'b1100);
        end
        repeat (4) applyStimulus(4'b0000, 4'b0000, -1, -1, 4'b0000);

        // Reset one cycle after a read grant discards that read.
        reqAddr[0] = 10'd1;
        applyStimulus(4'b0001, 4'b0000, 0, -1, 4'b0001);
        reset = 1'b1;
        rvQa.delete();
        rvQb.delete();
        applyStimulus(4'b1111, 4'b0000, -1, -1, 4'b0000);
        req = '0;
        @(negedge clock);
        checkOutput("midreset_read_address_a", read_address_a, 0);
        checkOutput("midreset_write_address_a", write_address_a, 0);
        checkOutput("midreset_data_a", data_a, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (5) applyStimulus(4'b0000, 4'b0000, -1, -1, 4'b0000);
        // The pointer is back at 0.
        applyStimulus(4'b1111, 4'b0000, 0, 1, 4'b0011);

        // Let the remaining expected outputs arrive, then flag any leftovers.
        for (int i = 0; i < 12; i++) begin
            if (gntQ.size() + wrQa.size() + wrQb.size() + rvQa.size() + rvQb.size() == 0) break;
            applyStimulus(4'b0000, 4'b0000, -1, -1, 4'b0000);
        end
        @(negedge clock);
        checkOutput("queue_leftover", gntQ.size() + wrQa.size() + wrQb.size() + rvQa.size() + rvQb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
